// File: rtl/reg_16bit_pkg.sv
// Shared definitions for the 16-bit storage register and the register file that uses it.
// Build option REG_16BIT_PARITY_EN adds a stored parity bit to reg_16bit.
package reg_16bit_pkg;

    localparam int REG_WIDTH = 16;
    localparam logic [REG_WIDTH-1:0] REG_RESET_VALUE = 16'h0000;

    typedef logic [REG_WIDTH-1:0] reg_word_t;

endpackage

// File: rtl/reg_16bit_dff_ar.sv
// Single-bit D flop with asynchronous active-high reset and a per-instance reset value.
// Latency 1 cycle; no backpressure, captures i_d on every rising edge outside reset.
module dff_ar #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= RESET_VAL;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/reg_16bit.sv
// Plain WIDTH-bit storage register built from per-bit async-reset flops; 1-cycle latency, no enable/backpressure.
// Define REG_16BIT_PARITY_EN to add a stored even-parity bit and the parity_err output.
module reg_16bit
    import reg_16bit_pkg::*;
#(
    parameter int               WIDTH       = REG_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(REG_RESET_VALUE)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
`ifdef REG_16BIT_PARITY_EN
    output logic [WIDTH-1:0] out,
    output logic             parity_err
`else
    output logic [WIDTH-1:0] out
`endif
);

    logic [WIDTH-1:0] w_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff_ar #(
            .RESET_VAL (RESET_VALUE[i])
        ) u_ff (
            .i_clk (clk),
            .i_rst (reset),
            .i_d   (in[i]),
            .o_q   (w_q[i])
        );
    end

    assign out = w_q;

`ifdef REG_16BIT_PARITY_EN
    logic w_par_d;
    logic w_par_q;

    // Parity flop resets to 0, which matches the all-zero data reset value.
    assign w_par_d = ^in;

    dff_ar #(
        .RESET_VAL (1'b0)
    ) u_par (
        .i_clk (clk),
        .i_rst (reset),
        .i_d   (w_par_d),
        .o_q   (w_par_q)
    );

    assign parity_err = (^w_q) ^ w_par_q;
`endif

endmodule

// File: tb/tb_reg_16bit.sv
module tb_reg_16bit;

    logic        clk;
    logic        reset;
    logic [15:0] d_in;
    logic [15:0] q_out;
`ifdef REG_16BIT_PARITY_EN
    logic        par_err;
`endif

    int          total;
    int          bad;
    logic [15:0] m_out;
    bit          chk_en;

    reg_16bit dut (
        .clk        (clk),
        .reset      (reset),
        .in         (d_in),
`ifdef REG_16BIT_PARITY_EN
        .out        (q_out),
        .parity_err (par_err)
`else
        .out        (q_out)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the register holds whatever was on in at the last edge outside reset.
    task automatic step(input logic [15:0] v);
        d_in = v;
        @(posedge clk);
        if (!reset) m_out = v;
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cycle_out", q_out, m_out);
`ifdef REG_16BIT_PARITY_EN
            check("cycle_parity", {15'd0, par_err}, 16'd0);
`endif
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        total  = 0;
        bad    = 0;
        chk_en = 1'b0;
        reset  = 1'b0;
        d_in   = 16'hBEEF;
        m_out  = 16'h0000;

        // Async reset before any clock edge.
        #2 reset = 1'b1;
        #1 check("rst_async", q_out, 16'h0000);
`ifdef REG_16BIT_PARITY_EN
        check("rst_parity", {15'd0, par_err}, 16'd0);
`endif
        chk_en = 1'b1;
        repeat (3) step(16'hBEEF);
        check("rst_held", q_out, 16'h0000);

        @(negedge clk);
        reset = 1'b0;
        step(16'h1234);
        check("load_1234", q_out, 16'h1234);
        d_in = 16'h0F0F;
        #2 check("no_change_mid", q_out, 16'h1234);
        step(16'hFFFF);
        check("load_ffff", q_out, 16'hFFFF);

        // Hold by real feedback of out into in.
        step(16'hA5A5);
        for (int k = 0; k < 10; k++) begin
            d_in = q_out;
            @(posedge clk);
            #1 check("hold_a5a5", q_out, 16'hA5A5);
        end
        step(16'h5A5A);
        check("inject_5a5a", q_out, 16'h5A5A);

        // Mid-cycle reset pulse.
        step(16'hCAFE);
        check("load_cafe", q_out, 16'hCAFE);
        #1 reset = 1'b1;
        m_out = 16'h0000;
        #1 check("mid_rst", q_out, 16'h0000);
        #1 reset = 1'b0;
        step(16'h0001);
        check("after_rst", q_out, 16'h0001);

        for (int i = 0; i < 16; i++) begin
            logic [15:0] w;
            w = 16'h0001 << i;
            step(w);
            check("walk_one", q_out, w);
        end

        for (int n = 0; n < 300; n++) begin
            logic [15:0] v;
            v = 16'($urandom);
            step(v);
            check("rand_load", q_out, v);
            if ($urandom_range(0, 9) == 0) begin
                #1 reset = 1'b1;
                m_out = 16'h0000;
                #1 check("rand_rst", q_out, 16'h0000);
                #1 reset = 1'b0;
            end
        end

`ifdef REG_16BIT_PARITY_EN
        step(16'h0007);
        check("par_clean", {15'd0, par_err}, 16'd0);
        chk_en = 1'b0;
        force dut.g_bit[1].u_ff.r_q = 1'b0;
        #1 check("par_upset", {15'd0, par_err}, 16'd1);
        release dut.g_bit[1].u_ff.r_q;
        step(16'h0000);
        check("par_recover", {15'd0, par_err}, 16'd0);
        check("par_recover_out", q_out, 16'h0000);
        chk_en = 1'b1;
`endif

        step(16'h8001);
        check("final_load", q_out, 16'h8001);
        @(negedge clk);
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
